data_reception_unit: RTL
========================

# data_reception_unit

Receive-side counterpart of the chip's 32-bit word transmitter. It samples a framed serial bitstream on the bit-rate clock and reassembles it into 32-bit words. Each good word is pushed into the RX FIFO through an active-low write strobe. Framing, parity and overflow errors are counted, and the counters are readable by slow control.

## Interface
Parameters:
- DATA_W, 32, payload bits per frame; MSB transmitted first.
- CNT_W, 8, width of each saturating error counter.

Ports:
- clk640MHz_i  input  1  bit-rate clock; the only clock.
- rst_i  input  1  reset, synchronous, active-high.
- ser_data_i  input  1  serial line; synchronous to clk640MHz_i; idles at 0.
- rx_fifo_full_i  input  1  RX FIFO full flag.
- rx_fifo_wdata_o  output  DATA_W  word presented to the RX FIFO.
- rx_fifo_wr_n_o  output  1  FIFO write strobe, active-low, one cycle per word.
- clr_cnt_i  input  1  synchronous clear of all error counters.
- frame_err_cnt_o  output  CNT_W  count of frames with a bad stop bit.
- parity_err_cnt_o  output  CNT_W  count of frames with a parity mismatch; constant 0 without RX_PARITY_EN.
- ovf_cnt_o  output  CNT_W  count of good frames dropped because the FIFO was full.

## Operation
- Frame format: start bit 1, then DATA_W data bits MSB first, then an even-parity bit (RX_PARITY_EN only), then stop bit 0.
  - 34 bits per frame without the parity bit, 35 with it.
- ser_data_i passes through one input register (ser_q) before the FSM sees it. All FSM decisions use ser_q.
- FSM states:
  - IDLE: when ser_q = 1, go to DATA, bit_cnt <= 0, parity accumulator <= 0.
  - DATA: shift ser_q into the shift register LSB, XOR it into the accumulator, increment bit_cnt.
    - When bit_cnt = DATA_W-1, go to PARITY if RX_PARITY_EN is defined, otherwise go to STOP.
  - PARITY: XOR ser_q into the accumulator; go to STOP.
  - STOP: evaluate the frame (rules below); go to IDLE.
- Frame evaluation in STOP, first matching rule wins; at most one counter increments per frame:
  1. ser_q = 1 (bad stop bit): frame_err_cnt +1, word discarded.
  2. Accumulator = 1 (parity mismatch, RX_PARITY_EN only): parity_err_cnt +1, word discarded.
  3. rx_fifo_full_i = 1: ovf_cnt +1, word discarded.
  4. Otherwise: rx_fifo_wdata_o <= shift register, rx_fifo_wr_n_o <= 0 for exactly the next cycle.
- Counters saturate at 2^CNT_W-1 and never wrap. If clr_cnt_i coincides with an increment, the clear wins and the counter reads 0.
- rx_fifo_wdata_o holds the last written word until the next write. It changes only together with a write strobe.
- Resync after a bad stop bit: the FSM re-enters IDLE. A line stuck at 1 therefore produces a 34-bit-periodic stream of frame errors, and no writes.

## Timing
- Reset values: rx_fifo_wr_n_o = 1, rx_fifo_wdata_o = 0, all counters 0, state IDLE, ser_q = 0, shift register 0.
- Reset mid-frame abandons the frame: no write, no counter change.
- Latency: if the stop bit is on ser_data_i in cycle n, it is in ser_q in cycle n+1, evaluated at the edge ending n+1, and rx_fifo_wr_n_o is low during cycle n+2.
- Back-to-back frames are supported: a start bit may directly follow a stop bit with no idle gap. Sustained rate is one word per 34 (or 35) cycles.
- rx_fifo_full_i is sampled only in the STOP cycle. It never stalls reception, so there is no backpressure on the line.
- A write strobe is never asserted in two consecutive cycles.

## Configuration
- RX_PARITY_EN defined:
  - PARITY state present; frame is 35 bits.
  - Parity-mismatched frames are dropped and counted in parity_err_cnt_o.
- RX_PARITY_EN undefined:
  - Frame is 34 bits; no PARITY state or accumulator logic.
  - parity_err_cnt_o is tied to 0.
- The transmitter must be built with the matching setting.

## Structure
- Package data_rx_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants START_BIT = 1, STOP_BIT = 0, IDLE_LVL = 0;
  - localparam FRAME_LEN, derived from DATA_W and RX_PARITY_EN.
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, clr, inc, cnt), instantiated three times.

## Test plan
- Frame with data 0xA5C3_0F12 and correct parity/stop -> rx_fifo_wr_n_o low for one cycle, exactly 2 cycles after the stop bit; rx_fifo_wdata_o = 0xA5C3_0F12; all counters 0.
- Two back-to-back frames 0x0000_0001 and 0xFFFF_FFFF, no idle gap -> two strobes exactly FRAME_LEN cycles apart, with matching data.
- Frame with stop bit 1 -> no write, frame_err_cnt_o = 1; a following good frame 0x1234_5678 is written normally.
- (RX_PARITY_EN) Frame 0x0000_0003 with parity bit 1 -> no write, parity_err_cnt_o = 1, frame_err_cnt_o = 0.
- rx_fifo_full_i = 1 during 300 good frames -> no writes, ovf_cnt_o = 255. Then pulse clr_cnt_i in the same cycle as another overflow -> ovf_cnt_o = 0.
- rst_i asserted at data bit 17 of a frame -> no write, outputs at reset values. The next complete frame 0xDEAD_BEEF is written correctly.

Source files
------------

// File: rtl/data_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// The frame length depends on the RX_PARITY_EN macro.
package data_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    localparam int RX_DATA_W = 32;
`ifdef RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_LEN = 1 + RX_DATA_W + PARITY_BITS + 1;

endpackage

// File: rtl/data_reception_unit_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/data_reception_unit.sv
// Serial frame receiver: reassembles framed words and writes good ones to the RX FIFO.
// Optional even-parity checking is enabled by defining RX_PARITY_EN.
module data_reception_unit
    import data_rx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk640MHz_i,
    input  logic              rst_i,
    input  logic              ser_data_i,
    input  logic              rx_fifo_full_i,
    output logic [DATA_W-1:0] rx_fifo_wdata_o,
    output logic              rx_fifo_wr_n_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  frame_err_cnt_o,
    output logic [CNT_W-1:0]  parity_err_cnt_o,
    output logic [CNT_W-1:0]  ovf_cnt_o
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e         state_q, state_d;
    logic              ser_q;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_n_q, wr_n_d;
    logic              frame_err_inc;
    logic              ovf_inc;
`ifdef RX_PARITY_EN
    logic              acc_q, acc_d;
    logic              parity_err_inc;
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        wdata_d       = wdata_q;
        wr_n_d        = 1'b1;
        frame_err_inc = 1'b0;
        ovf_inc       = 1'b0;
`ifdef RX_PARITY_EN
        acc_d          = acc_q;
        parity_err_inc = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ser_q == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
`ifdef RX_PARITY_EN
                    acc_d     = 1'b0;
`endif
                end
            end
            DATA: begin
                shift_d   = {shift_q[DATA_W-2:0], ser_q};
                bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef RX_PARITY_EN
                acc_d     = acc_q ^ ser_q;
`endif
                if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
`ifdef RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                acc_d   = acc_q ^ ser_q;
                state_d = STOP;
            end
`endif
            STOP: begin
                // Exactly one outcome per frame; earlier checks take priority.
                state_d = IDLE;
                if (ser_q != STOP_BIT) begin
                    frame_err_inc = 1'b1;
`ifdef RX_PARITY_EN
                end else if (acc_q) begin
                    parity_err_inc = 1'b1;
`endif
                end else if (rx_fifo_full_i) begin
                    ovf_inc = 1'b1;
                end else begin
                    wdata_d = shift_q;
                    wr_n_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk640MHz_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ser_q     <= IDLE_LVL;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wdata_q   <= '0;
            wr_n_q    <= 1'b1;
`ifdef RX_PARITY_EN
            acc_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ser_q     <= ser_data_i;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            wr_n_q    <= wr_n_d;
`ifdef RX_PARITY_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign rx_fifo_wdata_o = wdata_q;
    assign rx_fifo_wr_n_o  = wr_n_q;

    sat_counter #(.CNT_W(CNT_W)) u_frame_err_cnt (
        .clk (clk640MHz_i),
        .rst (rst_i),
        .clr (clr_cnt_i),
        .inc (frame_err_inc),
        .cnt (frame_err_cnt_o)
    );

`ifdef RX_PARITY_EN
    sat_counter #(.CNT_W(CNT_W)) u_parity_err_cnt (
        .clk (clk640MHz_i),
        .rst (rst_i),
        .clr (clr_cnt_i),
        .inc (parity_err_inc),
        .cnt (parity_err_cnt_o)
    );
`else
    assign parity_err_cnt_o = '0;
`endif

    sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk (clk640MHz_i),
        .rst (rst_i),
        .clr (clr_cnt_i),
        .inc (ovf_inc),
        .cnt (ovf_cnt_o)
    );

endmodule
